usb_wb_master: RTL and testbench
================================

# usb_wb_master

Wishbone pipelined bus initiator that drives the register slave port of the USB device core. It accepts single-beat read/write commands on a valid/ready command channel, runs the Wishbone cycle with stall and ack handling, and returns read data or a timeout error on a valid/ready response channel. It sits in the `i_wb_clk` domain between a control source (CPU bridge, test sequencer) and the USB device's `wbs` slave.

## Interface

Parameters:
- `ADDR_W`, 32: Wishbone address width.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT`, 256: maximum cycles to wait for ack, counted from the first `stb` cycle; minimum 2.

Ports:
- `i_wb_clk` in 1: single clock for all logic.
- `i_wb_reset` in 1: synchronous, active-high reset.
- `i_cmd_valid` in 1: a command is offered.
- `o_cmd_ready` out 1: the command is accepted when valid && ready.
- `i_cmd_we` in 1: 1 = write, 0 = read.
- `i_cmd_addr` in ADDR_W: target address.
- `i_cmd_data` in DATA_W: write data.
- `i_cmd_sel` in DATA_W/8: byte enables.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone master controls.
- `o_wb_addr` out ADDR_W, `o_wb_data` out DATA_W, `o_wb_sel` out DATA_W/8: Wishbone request fields.
- `i_wb_stall` in 1: slave cannot accept `stb` this cycle.
- `i_wb_ack` in 1: transfer complete.
- `i_wb_data` in DATA_W: read data, valid with ack.
- `o_rsp_valid` out 1: response available.
- `i_rsp_ready` in 1: the response is consumed when valid && ready.
- `o_rsp_data` out DATA_W: captured read data; 0 for writes and on timeout.
- `o_rsp_err` out 1: 1 = timeout.

## Operation

- States: IDLE, REQ, WAIT, RSP. All outputs are registered.
- IDLE:
  - `o_cmd_ready` = 1.
  - On accept, latch we/addr/data/sel onto the `o_wb_*` fields, clear the timeout counter, and go to REQ.
- REQ:
  - `cyc` = `stb` = 1.
  - If `i_wb_stall` = 0, the request is issued that cycle.
  - If `i_wb_ack` is also high that same cycle, go to RSP. Otherwise go to WAIT with `stb` dropped.
  - If stalled, stay in REQ with all fields held stable.
- WAIT:
  - `cyc` = 1, `stb` = 0.
  - On `i_wb_ack`, go to RSP.
- Ack capture: `i_wb_ack` is sampled only while `o_wb_cyc` = 1 and the request has issued (or issues in the same cycle).
  - `o_rsp_data` = `i_wb_data` for reads, 0 for writes.
  - `o_rsp_err` = 0.
  - `cyc` drops on entry to RSP.
- Timeout:
  - The counter increments every cycle in REQ and WAIT. The first `stb` cycle counts as 1.
  - If no ack arrives by the end of cycle `TIMEOUT`, drop `cyc` and `stb` and go to RSP with `o_rsp_err` = 1 and `o_rsp_data` = 0.
  - An ack in the expiry cycle wins: normal completion, err = 0.
- RSP:
  - `o_rsp_valid` = 1; data and err are held stable.
  - On `i_rsp_ready`, go to IDLE.
  - `o_cmd_ready` is 0 throughout RSP, so there is never more than one transaction in flight.
- Stray acks (`cyc` = 0, or in RSP/IDLE) are ignored.
- Counter width: `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing

- Reset values: `o_cmd_ready` = 0 during reset and 1 on the first cycle after reset deasserts. All other outputs (`o_wb_cyc`, `stb`, `we`, `addr`, `data`, `sel`, `o_rsp_valid`, `o_rsp_data`, `o_rsp_err`) are 0.
- Reset mid-transaction: `cyc`/`stb` are 0 on the next edge. No response is produced and the in-flight command is lost.
- Cycle numbering: command accepted at edge N → `cyc`/`stb` high in cycle N+1.
- Best case: no stall and ack in N+1 → `o_rsp_valid` high in N+2, `cyc` low in N+2.
- `stb` stays high for exactly (stall cycles + 1) cycles.
- Response consumed at edge M → `o_cmd_ready` high in M+1. Maximum throughput is one transfer per 3 cycles.
- `o_rsp_valid` is held until consumed. `o_rsp_data` and `o_rsp_err` do not change while `o_rsp_valid` = 1.

## Test plan

- Zero-wait write: cmd we=1, addr 0x10, data 0xDEADBEEF, sel 0xF; slave acks with no stall.
  - Expect `stb` high for 1 cycle carrying those fields.
  - Expect `rsp_valid` 2 cycles after accept, with data 0 and err 0.
- Stalled read: stall = 1 for 3 cycles, ack 2 cycles after issue with `i_wb_data` = 0x12345678.
  - Expect `stb` high for 4 cycles with stable addr.
  - Expect response data 0x12345678, err 0.
- Timeout: TIMEOUT=8, slave never acks.
  - Expect `cyc` high for exactly 8 cycles.
  - Expect a response with err 1 and data 0.
  - A late ack 3 cycles later is ignored: no second response, no state change.
- Ack exactly at the expiry cycle (TIMEOUT=8, ack in cycle 8, data 0xA5A5A5A5) → err 0, data 0xA5A5A5A5.
- Response backpressure: `rsp_ready` = 0 for 5 cycles while a second command is offered.
  - Expect `o_cmd_ready` = 0 and the response held stable for those cycles.
  - Expect the second command accepted the cycle after `rsp_ready` = 1.
- Reset asserted during WAIT:
  - Expect `cyc` = 0, `rsp_valid` = 0, and `cmd_ready` = 0 while reset is held.
  - After release, `cmd_ready` = 1 and a new read completes normally.

Source files
------------

// File: rtl/usb_wb_master.sv
// Wishbone pipelined initiator for the USB device register port. It runs one single-beat read or write at a time.
// Latency: command accepted at edge N puts cyc/stb up in N+1. With no stall and an immediate ack, the response is valid in N+2.
// Backpressure: cmd_ready is low from accept until the response is consumed. A stalled stb holds every request field. The response is held until rsp_ready.
//
// Ports:
//   i_wb_clk, i_wb_reset          : clock and synchronous active-high reset
//   i_cmd_* / o_cmd_ready          : command channel (we, addr, data, sel)
//   o_wb_* / i_wb_stall/ack/data   : Wishbone pipelined master side
//   o_rsp_* / i_rsp_ready          : response channel (read data, timeout error)
module usb_wb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_W-1:0]     i_cmd_addr,
  input  logic [DATA_W-1:0]     i_cmd_data,
  input  logic [DATA_W/8-1:0]   i_cmd_sel,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_W-1:0]     o_wb_addr,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic [DATA_W/8-1:0]   o_wb_sel,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_ack,
  input  logic [DATA_W-1:0]     i_wb_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_data,
  output logic                  o_rsp_err
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic                r_cyc, w_cyc_nxt;
  logic                r_stb, w_stb_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [SEL_W-1:0]    r_sel;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic                w_ack, w_expire, w_load, w_rsp_load;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cyc_nxt       = r_cyc;
    w_stb_nxt       = r_stb;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = '0;
    w_rsp_err_nxt   = 1'b0;
    w_load          = 1'b0;
    w_rsp_load      = 1'b0;
    // The counter value seen in a REQ/WAIT cycle is the number of cycles before this one.
    // w_cnt_inc is therefore the 1-based number of the current cycle. It saturates so it can never wrap.
    w_cnt_inc       = (r_cnt >= CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    w_expire        = (w_cnt_inc >= CNT_MAX);
    // An ack only counts once the request is on the bus, either issuing now or already issued.
    w_ack           = i_wb_ack && r_cyc &&
                      (((r_state == S_REQ) && !i_wb_stall) || (r_state == S_WAIT));
    case (r_state)
      S_IDLE: begin
        if (r_cmd_ready && i_cmd_valid) begin
          w_state_nxt = S_REQ;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      S_REQ, S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        // An ack arriving in the expiry cycle takes priority over the timeout.
        if (w_ack || w_expire) begin
          w_state_nxt     = S_RSP;
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_load      = 1'b1;
          w_rsp_err_nxt   = !w_ack;
          w_rsp_data_nxt  = (w_ack && !r_we) ? i_wb_data : '0;
        end else if ((r_state == S_REQ) && !i_wb_stall) begin
          w_state_nxt = S_WAIT;
          w_stb_nxt   = 1'b0;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_cyc       <= w_cyc_nxt;
      r_stb       <= w_stb_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_load) begin
        r_we   <= i_cmd_we;
        r_addr <= i_cmd_addr;
        r_data <= i_cmd_data;
        r_sel  <= i_cmd_sel;
      end
      if (w_rsp_load) begin
        r_rsp_data <= w_rsp_data_nxt;
        r_rsp_err  <= w_rsp_err_nxt;
      end
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_addr   = r_addr;
  assign o_wb_data   = r_data;
  assign o_wb_sel    = r_sel;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_usb_wb_master.sv
// Bench for usb_wb_master with TIMEOUT=8. Each transaction is described by its stall count, ack delay and read data.
// The expected timeline of each transaction is derived from those numbers and checked against the DUT every cycle.
// Directed scenarios come first and are followed by randomized transactions.
module tb_usb_wb_master;
  localparam int T     = 8;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        i_wb_reset = 1'b1;
  logic        i_cmd_valid = 1'b0, i_cmd_we = 1'b0;
  logic [31:0] i_cmd_addr = '0, i_cmd_data = '0;
  logic [3:0]  i_cmd_sel = '0;
  logic        i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_rsp_ready = 1'b0;
  logic [31:0] i_wb_data = '0;
  logic        o_cmd_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err;
  logic [31:0] o_wb_addr, o_wb_data, o_rsp_data;
  logic [3:0]  o_wb_sel;

  usb_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .i_wb_clk(clk), .i_wb_reset(i_wb_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_sel(i_cmd_sel),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err)
  );

  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;

  // Pending command plan (applied when accepted)
  bit          p_we;
  logic [31:0] p_addr, p_data, p_rdata;
  logic [3:0]  p_sel;
  int          p_stall, p_d;

  // Transaction-level model: rel = cycle number since accept (1 = first stb cycle)
  bit          m_live = 0, m_ready = 0, m_busy = 0, m_zero = 1, m_acc = 0, m_err = 0, m_we = 0;
  int          m_rel = 0, m_I = 0, m_A = 0, m_C = 0;
  logic [31:0] m_addr = '0, m_data = '0, m_rdata = '0;
  logic [3:0]  m_sel = '0;

  // Observations of the DUT used for hand-computed literal checks
  int          ncyc = 0, mon_stb = 0, mon_cyc = 0, mon_rsp = 0, mon_rsp_t = 0;
  int          mon_acc_t = 0, mon_cons_t = 0;
  logic [31:0] mon_rdata = '0;
  bit          mon_rerr = 0, prev_rv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit e_cyc, e_stb, e_rv;
    e_cyc = m_busy && (m_rel <= m_C);
    e_stb = m_busy && (m_rel <= m_I) && (m_rel <= m_C);
    e_rv  = m_busy && (m_rel > m_C);
    chk("cmd_ready", 32'(o_cmd_ready), 32'(m_ready));
    chk("wb_cyc", 32'(o_wb_cyc), 32'(e_cyc));
    chk("wb_stb", 32'(o_wb_stb), 32'(e_stb));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(e_rv));
    if (e_cyc) begin
      chk("wb_we", 32'(o_wb_we), 32'(m_we));
      chk("wb_addr", o_wb_addr, m_addr);
      chk("wb_data", o_wb_data, m_data);
      chk("wb_sel", 32'(o_wb_sel), 32'(m_sel));
    end
    if (e_rv) begin
      chk("rsp_data", o_rsp_data, (m_err || m_we) ? 32'h0 : m_rdata);
      chk("rsp_err", 32'(o_rsp_err), 32'(m_err));
    end
    if (m_zero && !m_busy) begin
      chk("rst_wb_we", 32'(o_wb_we), 32'h0);
      chk("rst_wb_addr", o_wb_addr, 32'h0);
      chk("rst_wb_data", o_wb_data, 32'h0);
      chk("rst_wb_sel", 32'(o_wb_sel), 32'h0);
      chk("rst_rsp_data", o_rsp_data, 32'h0);
      chk("rst_rsp_err", 32'(o_rsp_err), 32'h0);
    end
  endtask

  task automatic model_update();
    m_acc = 0;
    if (i_wb_reset) begin
      m_ready = 0; m_busy = 0; m_zero = 1;
    end else if (m_busy) begin
      if (m_rel > m_C && i_rsp_ready) begin
        m_busy = 0; m_ready = 1;
      end else begin
        m_rel++;
      end
    end else if (m_ready && i_cmd_valid) begin
      m_busy = 1; m_rel = 1; m_ready = 0; m_zero = 0; m_acc = 1;
      m_we = p_we; m_addr = p_addr; m_data = p_data; m_sel = p_sel; m_rdata = p_rdata;
      m_I   = p_stall + 1;
      m_A   = (p_d < 0) ? NEVER : m_I + p_d;
      m_C   = (m_A <= T) ? m_A : T;
      m_err = (m_A > T);
    end else begin
      m_ready = 1;
    end
    m_live = 1;
  endtask

  // Slave behaviour for the cycle that has just started. It also injects acks that must be ignored.
  task automatic drive_slave();
    i_wb_data = $urandom;
    if (m_busy && m_rel <= m_C) begin
      if (m_rel < m_I) begin
        i_wb_stall = 1'b1;
        i_wb_ack   = 1'($urandom_range(0, 1));
      end else if (m_rel == m_I) begin
        i_wb_stall = 1'b0;
        i_wb_ack   = (m_A == m_I);
      end else begin
        i_wb_stall = 1'($urandom_range(0, 1));
        i_wb_ack   = (m_rel == m_A);
      end
      if (m_rel == m_A) i_wb_data = m_rdata;
    end else begin
      i_wb_stall = 1'($urandom_range(0, 1));
      i_wb_ack   = (m_busy && m_rel == m_C + 3) || ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (m_live) compare();
    ncyc++;
    if (o_wb_stb) mon_stb++;
    if (o_wb_cyc) mon_cyc++;
    if (o_rsp_valid && !prev_rv) begin
      mon_rsp++; mon_rsp_t = ncyc; mon_rdata = o_rsp_data; mon_rerr = o_rsp_err;
    end
    prev_rv = o_rsp_valid;
    if (i_cmd_valid && o_cmd_ready) mon_acc_t = ncyc;
    if (o_rsp_valid && i_rsp_ready) mon_cons_t = ncyc;
    @(posedge clk);
    #1;
    model_update();
    drive_slave();
  endtask

  task automatic offer(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int st, input int dl, input logic [31:0] rd);
    p_we = we; p_addr = a; p_data = d; p_sel = s; p_stall = st; p_d = dl; p_rdata = rd;
    i_cmd_we = we; i_cmd_addr = a; i_cmd_data = d; i_cmd_sel = s;
    i_cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      got = m_acc;
    end
    i_cmd_valid = 1'b0;
    chk("accept_within_bound", 32'(got), 32'h1);
  endtask

  task automatic wait_rsp();
    bit got = m_busy && (m_rel > m_C);
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      got = m_busy && (m_rel > m_C);
    end
    chk("rsp_within_bound", 32'(got), 32'h1);
  endtask

  task automatic consume(input int hold);
    i_rsp_ready = 1'b0;
    repeat (hold) step();
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    int s_stb, s_cyc, s_rsp;
    int st, dl, sel;

    // Reset
    repeat (3) step();
    chk("ready_in_reset", 32'(o_cmd_ready), 32'h0);
    i_wb_reset = 1'b0;
    step();
    chk("ready_after_reset", 32'(o_cmd_ready), 32'h1);

    // Zero-wait write
    s_stb = mon_stb;
    offer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0BADF00D);
    wait_accept(); wait_rsp(); consume(0);
    chk("zw_stb_cycles", 32'(mon_stb - s_stb), 32'd1);
    chk("zw_rsp_latency", 32'(mon_rsp_t - mon_acc_t), 32'd2);
    chk("zw_rsp_data", mon_rdata, 32'h0);
    chk("zw_rsp_err", 32'(mon_rerr), 32'h0);

    // Stalled read: 3 stall cycles, ack 2 cycles after issue
    s_stb = mon_stb;
    offer(1'b0, 32'h24, 32'h0, 4'hF, 3, 2, 32'h12345678);
    wait_accept(); wait_rsp(); consume(1);
    chk("st_stb_cycles", 32'(mon_stb - s_stb), 32'd4);
    chk("st_rsp_data", mon_rdata, 32'h12345678);
    chk("st_rsp_err", 32'(mon_rerr), 32'h0);

    // Timeout with a late ack while the response is held
    s_cyc = mon_cyc; s_rsp = mon_rsp;
    offer(1'b0, 32'h30, 32'h0, 4'h3, 0, -1, 32'h11112222);
    wait_accept(); wait_rsp(); consume(5);
    repeat (3) step();
    chk("to_cyc_cycles", 32'(mon_cyc - s_cyc), 32'd8);
    chk("to_rsp_err", 32'(mon_rerr), 32'h1);
    chk("to_rsp_data", mon_rdata, 32'h0);
    chk("to_rsp_count", 32'(mon_rsp - s_rsp), 32'd1);

    // Ack exactly in the expiry cycle, with and without stall
    offer(1'b0, 32'h34, 32'h0, 4'hF, 0, 7, 32'hA5A5A5A5);
    wait_accept(); wait_rsp(); consume(0);
    chk("exp_rsp_err", 32'(mon_rerr), 32'h0);
    chk("exp_rsp_data", mon_rdata, 32'hA5A5A5A5);
    offer(1'b0, 32'h38, 32'h0, 4'hF, 2, 5, 32'h5A5A5A5A);
    wait_accept(); wait_rsp(); consume(0);
    chk("exp2_rsp_data", mon_rdata, 32'h5A5A5A5A);

    // Response backpressure with a second command waiting
    offer(1'b0, 32'h40, 32'h0, 4'hF, 1, 1, 32'hCAFE0001);
    wait_accept(); wait_rsp();
    offer(1'b1, 32'h44, 32'h55AA55AA, 4'h5, 0, 0, 32'h0);
    consume(5);
    wait_accept();
    chk("bp_accept_after_consume", 32'(mon_acc_t - mon_cons_t), 32'd1);
    wait_rsp(); consume(0);

    // Reset during WAIT
    offer(1'b0, 32'h50, 32'h0, 4'hF, 0, -1, 32'h0);
    wait_accept();
    repeat (3) step();
    i_wb_reset = 1'b1;
    repeat (3) step();
    chk("rst_wait_cyc", 32'(o_wb_cyc), 32'h0);
    chk("rst_wait_rsp_valid", 32'(o_rsp_valid), 32'h0);
    chk("rst_wait_ready", 32'(o_cmd_ready), 32'h0);
    i_wb_reset = 1'b0;
    step();
    chk("rst_wait_ready_after", 32'(o_cmd_ready), 32'h1);
    offer(1'b0, 32'h54, 32'h0, 4'hF, 1, 1, 32'hC0FFEE00);
    wait_accept(); wait_rsp(); consume(0);
    chk("rst_wait_new_read", mon_rdata, 32'hC0FFEE00);

    // Randomized transactions
    for (int n = 0; n < 150; n++) begin
      st  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 10)) : int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      dl = -1;
      else if (sel == 1) dl = T - (st + 1);
      else               dl = int'($urandom_range(0, 3));
      offer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), st, dl, $urandom);
      wait_accept(); wait_rsp();
      consume(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
